nibble_serial_adder16: RTL and testbench

NIBBLE_SERIAL_ADDER16 -- requirements
Module: nibble_serial_adder16

---
 rtl/nibble_serial_adder16.sv | 132 +++++++++++++
 tb/tb_nibble_serial_adder16.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder16.sv
// Digit-serial add/subtract: one 4-bit carry-lookahead slice walks the operands
// a nibble per cycle, LSB first, and publishes the full result on entry to StDone.
module nibble_serial_adder16 #(
  parameter int unsigned N_NIBBLES = 4,
  localparam int unsigned W = 4 * N_NIBBLES
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         cin,
  input  logic         sub,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf,
  output logic         zero
);

  localparam int unsigned KW = (N_NIBBLES > 1) ? $clog2(N_NIBBLES) : 1;
  localparam logic [KW-1:0] LastK = KW'(N_NIBBLES - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e state_q, state_d;

  logic [W-1:0]  a_q, b_q, work_q, work_d;
  logic [W-1:0]  sum_q;
  logic          carry_q;
  logic [KW-1:0] k_q;
  logic          cout_q, ovf_q, zero_q;

  logic          accept;
  logic          last_digit;
  logic [3:0]    a_dig, b_dig, g, p, s_dig;
  logic [4:0]    c;

  // Operands are only captured when no operation is in flight.
  assign accept     = start && (state_q != StRun);
  assign last_digit = (k_q == LastK);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (last_digit) state_d = StDone;
      StDone:  state_d = start ? StRun : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output decode
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      StRun:   busy = 1'b1;
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

  // Single 4-bit carry-lookahead slice on digit k.
  always_comb begin
    a_dig = a_q[4*k_q +: 4];
    b_dig = b_q[4*k_q +: 4];
    g     = a_dig & b_dig;
    p     = a_dig ^ b_dig;
    c[0]  = carry_q;
    c[1]  = g[0] | (p[0] & c[0]);
    c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4]  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
          | (p[3] & p[2] & p[1] & p[0] & c[0]);
    s_dig = p ^ c[3:0];
  end

  always_comb begin
    work_d = work_q;
    work_d[4*k_q +: 4] = s_dig;
  end

  // Datapath: working registers advance in StRun; visible result only on the last digit.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      carry_q <= 1'b0;
      k_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b1;
    end else if (accept) begin
      a_q     <= x;
      b_q     <= sub ? ~y : y;
      carry_q <= sub ? 1'b1 : cin;
      k_q     <= '0;
    end else if (state_q == StRun) begin
      work_q  <= work_d;
      carry_q <= c[4];
      if (last_digit) begin
        k_q    <= '0;
        sum_q  <= work_d;
        cout_q <= c[4];
        ovf_q  <= (a_q[W-1] == b_q[W-1]) && (work_d[W-1] != a_q[W-1]);
        zero_q <= (work_d == '0);
      end else begin
        k_q <= k_q + 1'b1;
      end
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_nibble_serial_adder16.sv
// Directed bench for nibble_serial_adder16: expected values are hand-computed constants.
module tb_nibble_serial_adder16;

  logic        clk = 1'b0;
  logic        reset, start, cin, sub;
  logic [15:0] x, y;
  logic        busy, done, cout, ovf, zero;
  logic [15:0] sum;

  int checks = 0;
  int errors = 0;

  nibble_serial_adder16 #(.N_NIBBLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .x     (x),
    .y     (y),
    .cin   (cin),
    .sub   (sub),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf),
    .zero  (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge right after the accepting posedge; returns the cycle index in
  // which done is seen (cycle 0 = accept cycle) and how many cycles busy was high.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat      = 0;
    busy_cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      if (i > 1) @(negedge clk);
      if (i == 1) start = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  // Enter at a negedge; leaves at the negedge of the done cycle.
  task automatic run_op(input string tag, input logic [15:0] xa, input logic [15:0] yb,
                        input logic ci, input logic sb, input logic [15:0] e_sum,
                        input logic e_cout, input logic e_ovf, input logic e_zero);
    int lat, bc;
    x = xa; y = yb; cin = ci; sub = sb; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wait_done(lat, bc);
    check({tag, "_lat"}, lat, 5);
    check({tag, "_busy"}, bc, 4);
    check({tag, "_sum"}, sum, e_sum);
    check({tag, "_cout"}, cout, e_cout);
    check({tag, "_ovf"}, ovf, e_ovf);
    check({tag, "_zero"}, zero, e_zero);
  endtask

  initial begin
    int lat, bc, glitches, dones;
    logic [15:0] held;

    reset = 1'b1; start = 1'b1; x = 16'h1234; y = 16'h1111; cin = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    // Start was high alongside reset: must not have launched anything.
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    check("rst_zero", zero, 1);
    reset = 1'b0;

    // First start on the first edge with reset low.
    run_op("add1", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    run_op("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    run_op("povf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    run_op("novf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    run_op("cin", 16'h00FF, 16'h0F00, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    run_op("sub", 16'h5000, 16'h1234, 1'b1, 1'b1, 16'h3DCC, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    run_op("borrow", 16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);

    // Start held high through RUN with new operands is ignored; start in DONE is taken.
    @(negedge clk);
    x = 16'h0001; y = 16'h0001; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    x = 16'hAAAA;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      if (i > 1) @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
    end
    check("hold_lat", lat, 5);
    check("hold_sum", sum, 16'h0002);
    @(posedge clk);
    @(negedge clk);
    wait_done(lat, bc);
    check("redone_lat", lat, 5);
    check("redone_sum", sum, 16'hAAAB);

    // Reset in the second RUN cycle aborts without a done pulse.
    @(negedge clk);
    x = 16'h1111; y = 16'h2222; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_sum", sum, 16'h0000);
    check("abort_zero", zero, 1);
    dones = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("abort_nodone", dones, 0);
    run_op("post", 16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b0);

    // Idle hold: done drops after one cycle, outputs stay put.
    held = sum;
    glitches = 0;
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) dones++;
      if (busy || sum !== held || zero !== 1'b0 || cout !== 1'b0) glitches++;
    end
    check("idle_done", dones, 0);
    check("idle_stable", glitches, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
